// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants, operand-stage entry layout and
// the result-bus snoop helper used at capture and on held entries.
package alu_pkg;

  localparam int XLEN = 64;
  localparam int OPW  = 8;
  localparam int REGW = 5;

  localparam logic [OPW-1:0] ALU_ADD  = 8'h01;
  localparam logic [OPW-1:0] ALU_SUB  = 8'h02;
  localparam logic [OPW-1:0] ALU_MUL  = 8'h03;
  localparam logic [OPW-1:0] ALU_AND  = 8'h04;
  localparam logic [OPW-1:0] ALU_OR   = 8'h05;
  localparam logic [OPW-1:0] ALU_NOT  = 8'h06;
  localparam logic [OPW-1:0] ALU_XOR  = 8'h07;
  localparam logic [OPW-1:0] ALU_SLL  = 8'h08;
  localparam logic [OPW-1:0] ALU_SRL  = 8'h09;
  localparam logic [OPW-1:0] ALU_GT   = 8'h0A;
  localparam logic [OPW-1:0] ALU_LT   = 8'h0B;
  localparam logic [OPW-1:0] ALU_EQ   = 8'h0C;
  localparam logic [OPW-1:0] ALU_CSET = 8'h0D;
  localparam logic [OPW-1:0] ALU_CINC = 8'h0E;
  localparam logic [OPW-1:0] ALU_CDEC = 8'h0F;
  localparam logic [OPW-1:0] ALU_OP_MAX = ALU_CDEC;

  typedef struct packed {
    logic            valid;
    logic [OPW-1:0]  op;
    logic [REGW-1:0] rd;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic            use_imm;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            illegal;
  } entry_t;

  function automatic logic op_illegal(logic [OPW-1:0] op);
    return (op == '0) || (op > ALU_OP_MAX);
  endfunction

  // Register 0 is never a forwarding target; immediates are never replaced.
  function automatic entry_t snoop_entry(entry_t e, logic hit_en,
                                         logic [REGW-1:0] rd, logic [XLEN-1:0] data);
    entry_t r;
    r = e;
    if (hit_en && rd != '0) begin
      if (e.rs1 == rd) r.a = data;
      if (!e.use_imm && e.rs2 == rd) r.b = data;
    end
    return r;
  endfunction

endpackage

// File: rtl/ex_operand_slot.sv
// One buffered entry of the operand stage; keeps its operands current with
// the result bus every cycle it holds, and exposes the snooped view.
module ex_operand_slot
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            clear,
  input  logic            fwd_hit_en,
  input  logic [REGW-1:0] fwd_rd,
  input  logic [XLEN-1:0] fwd_data,
  input  entry_t          d,
  output entry_t          q,
  output entry_t          q_snoop
);

  entry_t q_reg;
  entry_t q_next;

  assign q_snoop = snoop_entry(q_reg, fwd_hit_en, fwd_rd, fwd_data);

  // Clearing drops only the valid bit so the outputs keep their last values.
  always_comb begin
    q_next = q_snoop;
    if (load) q_next = d;
    if (clear) q_next.valid = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_reg <= '0;
    else        q_reg <= q_next;
  end

  assign q = q_reg;

endmodule

// File: rtl/ex_operand_stage.sv
// Two-entry operand issue stage feeding the ALU (main + skid buffer).
// Define EX_OPERAND_FWD_EN to enable result-bus forwarding and snooping.
module ex_operand_stage
  import alu_pkg::*;
#(
  parameter int XLEN = alu_pkg::XLEN,
  parameter int OPW  = alu_pkg::OPW,
  parameter int REGW = alu_pkg::REGW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  in_alu_op,
  input  logic [REGW-1:0] in_rd,
  input  logic [REGW-1:0] in_rs1,
  input  logic [REGW-1:0] in_rs2,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_use_imm,
  input  logic            fwd_valid,
  input  logic [REGW-1:0] fwd_rd,
  input  logic [XLEN-1:0] fwd_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [OPW-1:0]  out_alu_op,
  output logic [REGW-1:0] out_rd,
  output logic            out_illegal
);

  logic fwd_en;
`ifdef EX_OPERAND_FWD_EN
  assign fwd_en = fwd_valid;
`else
  logic unused_fwd;
  assign unused_fwd = fwd_valid;
  assign fwd_en     = 1'b0;
`endif

  entry_t cap_raw, cap;
  entry_t main_q, main_snp, main_d;
  entry_t skid_q, skid_snp;
  logic   main_load, main_clear, skid_load, skid_clear;
  logic   pop, accept;

  always_comb begin
    cap_raw         = '0;
    cap_raw.valid   = 1'b1;
    cap_raw.illegal = op_illegal(in_alu_op);
    cap_raw.op      = cap_raw.illegal ? '0 : in_alu_op;
    cap_raw.rd      = in_rd;
    cap_raw.rs1     = in_rs1;
    cap_raw.rs2     = in_rs2;
    cap_raw.use_imm = in_use_imm;
    cap_raw.a       = (in_rs1 == '0) ? '0 : in_rs1_data;
    cap_raw.b       = in_use_imm ? in_imm : ((in_rs2 == '0) ? '0 : in_rs2_data);
    cap             = snoop_entry(cap_raw, fwd_en, fwd_rd, fwd_data);
  end

  // in_ready comes straight from the skid valid flop, never from out_ready.
  assign in_ready = !skid_q.valid;
  assign pop      = main_q.valid && out_ready;
  assign accept   = in_valid && !skid_q.valid;

  always_comb begin
    main_load  = 1'b0;
    main_clear = 1'b0;
    main_d     = cap;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else if (pop) begin
      if (skid_q.valid) begin
        main_load  = 1'b1;
        main_d     = skid_snp;
        skid_clear = 1'b1;
      end else if (accept) begin
        main_load = 1'b1;
      end else begin
        main_clear = 1'b1;
      end
    end else if (accept) begin
      if (!main_q.valid) main_load = 1'b1;
      else               skid_load = 1'b1;
    end
  end

  ex_operand_slot u_main (
    .clk(clk), .rst_n(rst_n), .load(main_load), .clear(main_clear),
    .fwd_hit_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .d(main_d), .q(main_q), .q_snoop(main_snp)
  );

  ex_operand_slot u_skid (
    .clk(clk), .rst_n(rst_n), .load(skid_load), .clear(skid_clear),
    .fwd_hit_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .d(cap), .q(skid_q), .q_snoop(skid_snp)
  );

  assign out_valid   = main_q.valid;
  assign out_a       = main_q.a;
  assign out_b       = main_q.b;
  assign out_alu_op  = main_q.op;
  assign out_rd      = main_q.rd;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage; forwarding expectations follow
// whether EX_OPERAND_FWD_EN is defined for the build.
module tb_ex_operand_stage;

`ifdef EX_OPERAND_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_alu_op = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [63:0] in_rs1_data = '0, in_rs2_data = '0, in_imm = '0;
  logic        in_use_imm = 1'b0;
  logic        fwd_valid = 1'b0;
  logic [4:0]  fwd_rd = '0;
  logic [63:0] fwd_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_a, out_b;
  logic [7:0]  out_alu_op;
  logic [4:0]  out_rd;
  logic        out_illegal;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_alu_op(in_alu_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_alu_op(out_alu_op),
    .out_rd(out_rd), .out_illegal(out_illegal)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [63:0] d1,
                      input logic [4:0] rs2, input logic [63:0] d2,
                      input logic use_imm, input logic [63:0] imm);
    in_valid = 1'b1; in_alu_op = op; in_rd = rd;
    in_rs1 = rs1; in_rs1_data = d1; in_rs2 = rs2; in_rs2_data = d2;
    in_use_imm = use_imm; in_imm = imm;
  endtask

  task automatic idle;
    in_valid = 1'b0; in_use_imm = 1'b0;
  endtask

  initial begin
    #2;
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd1);
    check("rst out_a", out_a, 64'd0);
    check("rst out_b", out_b, 64'd0);
    check("rst out_alu_op", 64'(out_alu_op), 64'd0);
    check("rst out_rd", 64'(out_rd), 64'd0);
    check("rst out_illegal", 64'(out_illegal), 64'd0);
    tick; tick;
    rst_n = 1'b1;
    tick;

    // Basic issue
    out_ready = 1'b1;
    send(8'h01, 5'd1, 5'd3, 64'd5, 5'd4, 64'd7, 1'b0, 64'd0);
    tick; idle;
    check("basic valid", 64'(out_valid), 64'd1);
    check("basic a", out_a, 64'd5);
    check("basic b", out_b, 64'd7);
    check("basic op", 64'(out_alu_op), 64'h01);
    check("basic rd", 64'(out_rd), 64'd1);
    tick;
    check("basic drained", 64'(out_valid), 64'd0);

    // Capture-time forwarding, and register 0 is never forwarded
    send(8'h02, 5'd2, 5'd6, 64'h11, 5'd0, 64'h0, 1'b0, 64'd0);
    fwd_valid = 1'b1; fwd_rd = 5'd6; fwd_data = 64'hAA;
    tick;
    check("fwd capture a", out_a, FWD_ON ? 64'hAA : 64'h11);
    send(8'h02, 5'd2, 5'd0, 64'h22, 5'd0, 64'h0, 1'b0, 64'd0);
    fwd_rd = 5'd0; fwd_data = 64'hBB;
    tick; idle; fwd_valid = 1'b0;
    check("fwd x0 a", out_a, 64'd0);

    // Illegal / boundary opcodes and immediate
    send(8'h20, 5'd3, 5'd1, 64'd1, 5'd2, 64'd2, 1'b0, 64'd0);
    tick;
    check("op20 alu_op", 64'(out_alu_op), 64'h00);
    check("op20 illegal", 64'(out_illegal), 64'd1);
    send(8'h0F, 5'd3, 5'd1, 64'd1, 5'd2, 64'd2, 1'b0, 64'd0);
    tick;
    check("op0F alu_op", 64'(out_alu_op), 64'h0F);
    check("op0F illegal", 64'(out_illegal), 64'd0);
    send(8'h00, 5'd3, 5'd1, 64'd1, 5'd2, 64'd2, 1'b0, 64'd0);
    tick;
    check("op00 illegal", 64'(out_illegal), 64'd1);
    send(8'h01, 5'd4, 5'd1, 64'd9, 5'd2, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    tick; idle;
    check("imm b", out_b, 64'hFFFF_FFFF_FFFF_FFFC);
    tick;

    // Backpressure: three pushes, in order, no loss
    out_ready = 1'b0;
    send(8'h01, 5'd5, 5'd1, 64'd101, 5'd2, 64'd1, 1'b0, 64'd0);
    tick;
    check("bp ready after 1", 64'(in_ready), 64'd1);
    send(8'h01, 5'd6, 5'd1, 64'd102, 5'd2, 64'd1, 1'b0, 64'd0);
    tick;
    check("bp ready after 2", 64'(in_ready), 64'd0);
    send(8'h01, 5'd7, 5'd1, 64'd103, 5'd2, 64'd1, 1'b0, 64'd0);
    tick;
    check("bp hold a", out_a, 64'd101);
    out_ready = 1'b1;
    tick;
    check("bp 2nd a", out_a, 64'd102);
    check("bp 2nd rd", 64'(out_rd), 64'd6);
    check("bp ready back", 64'(in_ready), 64'd1);
    tick; idle;
    check("bp 3rd a", out_a, 64'd103);
    check("bp 3rd valid", 64'(out_valid), 64'd1);
    tick;
    check("bp empty", 64'(out_valid), 64'd0);

    // Snoop of an entry waiting in skid
    out_ready = 1'b0;
    send(8'h01, 5'd8, 5'd1, 64'd201, 5'd2, 64'd202, 1'b0, 64'd0);
    tick;
    send(8'h01, 5'd9, 5'd0, 64'd0, 5'd9, 64'h55, 1'b0, 64'd0);
    tick; idle;
    check("snoop skid full", 64'(in_ready), 64'd0);
    fwd_valid = 1'b1; fwd_rd = 5'd9; fwd_data = 64'h1234;
    tick; fwd_valid = 1'b0;
    check("snoop main b", out_b, 64'd202);
    out_ready = 1'b1;
    tick;
    check("snoop moved b", out_b, FWD_ON ? 64'h1234 : 64'h55);
    check("snoop moved rd", 64'(out_rd), 64'd9);
    tick;

    // Flush with an accept while ready, then with both entries full
    out_ready = 1'b0;
    send(8'h01, 5'd1, 5'd1, 64'd301, 5'd2, 64'd1, 1'b0, 64'd0);
    tick;
    flush = 1'b1;
    send(8'h01, 5'd2, 5'd1, 64'd302, 5'd2, 64'd1, 1'b0, 64'd0);
    tick; flush = 1'b0; idle;
    check("flush1 valid", 64'(out_valid), 64'd0);
    check("flush1 ready", 64'(in_ready), 64'd1);
    tick;
    check("flush1 dropped", 64'(out_valid), 64'd0);
    send(8'h01, 5'd3, 5'd1, 64'd303, 5'd2, 64'd1, 1'b0, 64'd0);
    tick;
    send(8'h01, 5'd4, 5'd1, 64'd304, 5'd2, 64'd1, 1'b0, 64'd0);
    tick;
    check("flush2 full", 64'(in_ready), 64'd0);
    flush = 1'b1;
    send(8'h01, 5'd5, 5'd1, 64'd305, 5'd2, 64'd1, 1'b0, 64'd0);
    tick; flush = 1'b0; idle;
    check("flush2 valid", 64'(out_valid), 64'd0);
    check("flush2 ready", 64'(in_ready), 64'd1);
    tick;
    check("flush2 dropped", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-operation
    send(8'h01, 5'd6, 5'd1, 64'd401, 5'd2, 64'd1, 1'b0, 64'd0);
    tick; idle;
    check("arst pre valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst valid", 64'(out_valid), 64'd0);
    check("arst a", out_a, 64'd0);
    tick;
    rst_n = 1'b1;
    tick;
    check("arst after", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
